if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage. Each cycle it accepts one fetched instruction word and its 10-bit address from fetch, buffers up to DEPTH entries, and presents the oldest entry to decode through a valid/ready handshake. On a taken branch it discards all buffered instructions, which are wrong-path. It also throttles fetch by deasserting InReady when full.

---
 rtl/if_id_queue_pkg.sv | 19 +
 rtl/if_id_queue.sv | 99 +++++++++
 tb/tb_if_id_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_id_queue_pkg
// Shared fetch/decode pipeline definitions:
//   NOP_INSTR      canonical no-op (addi x0,x0,0) shown to decode when idle
//   AW_DEF/IW_DEF  default instruction address / instruction widths
//   fetch_entry_t  one fetched instruction with its address, default widths
// -----------------------------------------------------------------------------
package if_id_queue_pkg;

  localparam int          AW_DEF    = 10;
  localparam int          IW_DEF    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [IW_DEF-1:0] instr;
    logic [AW_DEF-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// Instruction queue between fetch and decode. Buffers up to DEPTH fetched
// {instruction, address} pairs and hands the oldest one to decode through a
// valid/ready handshake. A taken branch flushes everything buffered.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   Reset        synchronous active-high reset, empties the queue
//   InValid      fetch offers Instruction/Add this cycle
//   Instruction  fetched instruction word (IW bits)
//   Add          address of the fetched instruction (AW bits)
//   InReady      queue has a free entry (depends on Count only)
//   Branch       taken branch resolved downstream; flush the queue
//   OutValid     head entry valid
//   OutInstr     head instruction, NOP when empty
//   OutAdd       head address, 0 when empty
//   OutReady     decode consumes the head this cycle
//   Count        number of occupied entries
// -----------------------------------------------------------------------------
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     InValid,
  input  logic [IW-1:0]            Instruction,
  input  logic [AW-1:0]            Add,
  output logic                     InReady,
  input  logic                     Branch,
  output logic                     OutValid,
  output logic [IW-1:0]            OutInstr,
  output logic [AW-1:0]            OutAdd,
  input  logic                     OutReady,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Same layout as fetch_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A branch cancels both sides: the incoming fetch is wrong-path and the
  // head must not be handed to decode in the flush cycle.
  assign w_push = InValid & ~w_full & ~Branch;
  assign w_pop  = ~w_empty & OutReady & ~Branch;

  assign InReady  = ~w_full;
  assign OutValid = ~w_empty;
  assign Count    = r_count;
  assign OutInstr = w_empty ? IW'(NOP_INSTR) : r_mem[r_rd_ptr].instr;
  assign OutAdd   = w_empty ? '0             : r_mem[r_rd_ptr].addr;

  // Storage carries no reset: contents are meaningless while Count says so.
  always_ff @(posedge clk) begin
    if (!Reset && w_push) begin
      r_mem[r_wr_ptr] <= '{instr: Instruction, addr: Add};
    end
  end

  // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (Reset || Branch) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_queue
// Scoreboard bench for if_id_queue. A feeder pushes every instruction the
// reference queue model accepts; a monitor pops the model on each decode
// handshake and compares the instruction delivered, and on every falling edge
// compares all outputs against the model's occupancy and head.
// -----------------------------------------------------------------------------
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          Reset, InValid, Branch, OutReady;
  logic [IW-1:0] Instruction;
  logic [AW-1:0] Add;
  logic          InReady, OutValid;
  logic [IW-1:0] OutInstr;
  logic [AW-1:0] OutAdd;
  logic [CW-1:0] Count;

  if_id_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk(clk), .Reset(Reset), .InValid(InValid), .Instruction(Instruction),
    .Add(Add), .InReady(InReady), .Branch(Branch), .OutValid(OutValid),
    .OutInstr(OutInstr), .OutAdd(OutAdd), .OutReady(OutReady), .Count(Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
  } item_t;

  item_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    m_size_pre = 0;   // model occupancy for the current cycle
  bit    started = 0;

  // DUT outputs captured at the falling edge, used at the next rising edge
  logic          s_ov;
  logic [IW-1:0] s_oi;
  logic [AW-1:0] s_oa;
  bit            held = 0;
  logic [IW-1:0] held_i;
  logic [AW-1:0] held_a;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", name, got, want, $time);
    end
  endtask

  // Feeder: reference acceptance rule (room in the model, no flush/reset).
  initial forever begin
    @(posedge clk);
    if (!Reset && !Branch && InValid && m_size_pre < DEPTH)
      exp_q.push_back('{instr: Instruction, addr: Add});
  end

  // Monitor, rising edge: flush or consume according to the handshake seen.
  initial forever begin
    @(posedge clk);
    if (Reset || Branch) begin
      exp_q.delete();
      held = 0;
      if (Reset) started = 1;
    end else if (started) begin
      if (s_ov && OutReady) begin
        if (m_size_pre == 0) begin
          check("pop_on_empty", 64'(s_ov), 64'd0);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("pop_instr", 64'(s_oi), 64'(e.instr));
          check("pop_addr",  64'(s_oa), 64'(e.addr));
          $display("pop  addr=%0h instr=%08h", s_oa, s_oi);
        end
      end
      held   = s_ov && !OutReady;
      held_i = s_oi;
      held_a = s_oa;
    end
  end

  // Monitor, falling edge: full output comparison against the model.
  initial forever begin
    @(negedge clk);
    s_ov = OutValid; s_oi = OutInstr; s_oa = OutAdd;
    m_size_pre = exp_q.size();
    if (started) begin
      check("count",    64'(Count),    64'(m_size_pre));
      check("inready",  64'(InReady),  64'(m_size_pre != DEPTH));
      check("outvalid", 64'(OutValid), 64'(m_size_pre != 0));
      if (m_size_pre == 0) begin
        check("idle_instr", 64'(OutInstr), 64'(NOP));
        check("idle_addr",  64'(OutAdd),   64'd0);
      end else begin
        check("head_instr", 64'(OutInstr), 64'(exp_q[0].instr));
        check("head_addr",  64'(OutAdd),   64'(exp_q[0].addr));
      end
      if (held) begin
        check("stable_instr", 64'(OutInstr), 64'(held_i));
        check("stable_addr",  64'(OutAdd),   64'(held_a));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: a fetch model that holds its offer until accepted.
  // ---------------------------------------------------------------------------
  bit pending = 0;

  task automatic step(input bit iv, input logic [AW-1:0] a, input bit br,
                      input bit ordy, input bit rst, output bit acc);
    bit rdy;
    Reset = rst; Branch = br; OutReady = ordy; InValid = iv;
    if (iv && !pending) begin
      Add = a;
      Instruction = $urandom;
    end
    @(negedge clk);
    rdy = InReady;
    @(posedge clk);
    #1;
    acc = iv && rdy && !br && !rst;
    pending = iv && !acc && !br && !rst;
    $display("cyc iv=%0b add=%0h br=%0b ordy=%0b rst=%0b acc=%0b cnt=%0d",
             iv, Add, br, ordy, rst, acc, Count);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int k = 0; k < n; k++) step(0, '0, 0, ordy, 0, acc);
  endtask

  initial begin
    bit acc;
    logic [AW-1:0] a;
    Reset = 1; InValid = 0; Branch = 0; OutReady = 0; Instruction = '0; Add = '0;
    step(0, '0, 0, 0, 1, acc);
    step(0, '0, 0, 0, 1, acc);

    // Three pushes with decode stalled, then a fourth fills the queue.
    for (int k = 0; k < 4; k++) step(1, AW'(4 * k), 0, 0, 0, acc);
    // Fifth offer held while full, then a pop frees room.
    step(1, 10'h10, 0, 0, 0, acc);
    step(1, 10'h10, 0, 0, 0, acc);
    step(1, 10'h10, 0, 1, 0, acc);
    step(1, 10'h10, 0, 0, 0, acc);
    if (pending) idle(0, 0);
    idle(6, 1);

    // Streaming with both sides always ready, across pointer wrap.
    a = '0;
    for (int k = 0; k < 45 && a <= 10'h28; k++) begin
      step(1, a, 0, 1, 0, acc);
      if (acc) a = a + AW'(4);
    end
    idle(3, 1);

    // Flush with concurrent push and pop, then the target fetch.
    for (int k = 0; k < 3; k++) step(1, AW'(10'h14 + 4 * k), 0, 0, 0, acc);
    step(1, 10'h20, 1, 1, 0, acc);
    step(1, 10'h3C, 0, 0, 0, acc);
    idle(2, 0);
    idle(2, 1);

    // Reset mid-operation with a concurrent push.
    step(1, 10'h40, 0, 0, 0, acc);
    step(1, 10'h44, 0, 0, 0, acc);
    step(1, 10'h48, 0, 1, 1, acc);
    idle(2, 1);

    // Random traffic with backpressure, rare flushes and resets.
    a = 10'h100;
    for (int k = 0; k < 400; k++) begin
      bit iv, ordy, br, rst;
      iv   = ($urandom_range(0, 3) != 0) || pending;
      ordy = $urandom_range(0, 2) != 0;
      br   = $urandom_range(0, 31) == 0;
      rst  = $urandom_range(0, 127) == 0;
      step(iv, a, br, ordy, rst, acc);
      if (acc || br || rst) a = a + AW'(4);
    end
    idle(6, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always ends even if stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
